// File: rtl/ta_sync_pkg.sv
// Shared definitions for the capture sync chain: FSM state encoding and
// default geometry for the capture RAM and inactivity watchdog.
package ta_sync_pkg;

  typedef enum logic [1:0] {
    S_RDY = 2'd0,
    S_CAP = 2'd1,
    S_END = 2'd2
  } sync_st_e;

  localparam int DEF_DW      = 16;
  localparam int DEF_AW      = 10;
  localparam int DEF_CAP_LEN = 1024;
  localparam int DEF_TO_W    = 16;

endpackage

// File: rtl/ta_sync_wdog.sv
// Inactivity counter: expire pulses on the tick that brings the count to
// all-ones, i.e. after 2^TO_W-1 consecutive ticks with no clear.
module ta_sync_wdog
  import ta_sync_pkg::*;
#(
  parameter int TO_W = DEF_TO_W
) (
  input  logic clk50,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam logic [TO_W-1:0] PRE = ~TO_W'(1);

  logic [TO_W-1:0] cnt;

  assign expire = tick & (cnt == PRE);

  always_ff @(posedge clk50) begin
    if (rst || clr)
      cnt <= '0;
    else if (tick && cnt != '1)
      cnt <= cnt + TO_W'(1);
  end

endmodule

// File: rtl/ta_sync_capture.sv
// Capture sink for the sync controller: on trigger, writes one burst of
// CAP_LEN valid samples to the capture RAM, guarded by an idle watchdog.
module ta_sync_capture
  import ta_sync_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int CAP_LEN = DEF_CAP_LEN,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic          clk50,
  input  logic          rst,
  input  logic          sync_trig,
  output logic          syncr_rdy,
  input  logic          mem_reset,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW:0]   cap_cnt,
  output logic          cap_done,
  output logic          cap_err
);

  localparam int          CW   = AW + 1;
  localparam logic [AW:0] LAST = CW'(CAP_LEN - 1);

  sync_st_e st;
  logic     wd_clr, wd_tick, wd_exp;

  // Watchdog only runs while capturing; any accepted sample restarts it.
  assign wd_clr  = (st != S_CAP) | din_vld;
  assign wd_tick = (st == S_CAP) & ~din_vld;

  ta_sync_wdog #(.TO_W(TO_W)) u_wdog (
    .clk50  (clk50),
    .rst    (rst),
    .clr    (wd_clr),
    .tick   (wd_tick),
    .expire (wd_exp)
  );

  always_ff @(posedge clk50) begin
    if (rst) begin
      st        <= S_RDY;
      syncr_rdy <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cap_cnt   <= '0;
      cap_done  <= 1'b0;
      cap_err   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (st)
        S_RDY: begin
          if (sync_trig) begin
            st        <= S_CAP;
            syncr_rdy <= 1'b0;
            cap_cnt   <= '0;
            cap_done  <= 1'b0;
            cap_err   <= 1'b0;
          end else if (mem_reset) begin
            cap_cnt   <= '0;
            cap_done  <= 1'b0;
            cap_err   <= 1'b0;
            wr_addr   <= '0;
          end
        end
        S_CAP: begin
          if (din_vld) begin
            wr_en   <= 1'b1;
            wr_addr <= cap_cnt[AW-1:0];
            wr_data <= din;
            cap_cnt <= cap_cnt + CW'(1);
            if (cap_cnt == LAST) begin
              cap_done <= 1'b1;
              st       <= S_END;
            end
          end else if (wd_exp) begin
            cap_err <= 1'b1;
            st      <= S_END;
          end
        end
        S_END: begin
          // Hold off ready until the controller drops its trigger level.
          if (!sync_trig) begin
            st        <= S_RDY;
            syncr_rdy <= 1'b1;
          end
        end
        default: begin
          st        <= S_RDY;
          syncr_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ta_sync_capture.sv
// Bench for ta_sync_capture with AW=3, CAP_LEN=8, TO_W=4.
module tb_ta_sync_capture;

  logic        clk50, rst, sync_trig, mem_reset, din_vld;
  logic [15:0] din;
  logic        syncr_rdy, wr_en, cap_done, cap_err;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  cap_cnt;

  ta_sync_capture #(.DW(16), .AW(3), .CAP_LEN(8), .TO_W(4)) dut (
    .clk50(clk50), .rst(rst), .sync_trig(sync_trig), .syncr_rdy(syncr_rdy),
    .mem_reset(mem_reset), .din(din), .din_vld(din_vld), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cap_cnt(cap_cnt),
    .cap_done(cap_done), .cap_err(cap_err)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [2:0] a; logic [15:0] d; } wr_t;
  wr_t q[$];
  logic mon_en = 1'b0;
  int   wr_seen = 0;

  typedef struct {
    logic rst, trig, mrst, vld; logic [15:0] din;
    logic e_rdy, e_wen; logic [3:0] e_cnt; logic e_done, e_err;
    logic chk_ad; logic [2:0] e_addr; logic [15:0] e_data;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk50); #1;
  endtask

  // Write-port scoreboard monitor.
  always @(negedge clk50) begin
    if (mon_en && wr_en) begin
      wr_t e;
      wr_seen++;
      if (q.size() == 0) begin
        chk("unexp_wr", {13'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  task automatic run_full(input logic [15:0] base, input string nm);
    int w0;
    w0 = wr_seen;
    sync_trig = 1'b1; din_vld = 1'b1; din = base;
    cyc();
    chk({nm, "_hs_rdy"}, 32'(syncr_rdy), 0);
    sync_trig = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = base + 16'(i);
      q.push_back({3'(i), base + 16'(i)});
      cyc();
    end
    chk({nm, "_cnt"}, 32'(cap_cnt), 8);
    chk({nm, "_done"}, 32'(cap_done), 1);
    chk({nm, "_err"}, 32'(cap_err), 0);
    chk({nm, "_rdy_end"}, 32'(syncr_rdy), 0);
    din_vld = 1'b0;
    cyc();
    chk({nm, "_rdy_back"}, 32'(syncr_rdy), 1);
    chk({nm, "_q"}, 32'(q.size()), 0);
    chk({nm, "_nwr"}, 32'(wr_seen - w0), 8);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int idle, w0;
    rst = 1'b1; sync_trig = 1'b0; mem_reset = 1'b0; din_vld = 1'b0; din = '0;

    //            rst trg mrs vld din      rdy wen cnt dn er  ad addr data
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,4'd0,1'b0,1'b0, 1'b1,3'd0,16'h0000};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,16'hAAAA, 1'b1,1'b0,4'd0,1'b0,1'b0, 1'b1,3'd0,16'h0000};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b0,4'd0,1'b0,1'b0, 1'b1,3'd0,16'h0000};
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b1,16'h0020, 1'b0,1'b0,4'd0,1'b0,1'b0, 1'b1,3'd0,16'h0000};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,16'h0021, 1'b0,1'b1,4'd1,1'b0,1'b0, 1'b1,3'd0,16'h0021};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,16'h0099, 1'b0,1'b0,4'd1,1'b0,1'b0, 1'b0,3'd0,16'h0000};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b1,16'h0022, 1'b0,1'b1,4'd2,1'b0,1'b0, 1'b1,3'd1,16'h0022};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,16'h0023, 1'b0,1'b1,4'd3,1'b0,1'b0, 1'b1,3'd2,16'h0023};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b1,16'h0024, 1'b1,1'b0,4'd0,1'b0,1'b0, 1'b1,3'd0,16'h0000};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,4'd0,1'b0,1'b0, 1'b1,3'd0,16'h0000};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; sync_trig = tbl[i].trig; mem_reset = tbl[i].mrst;
      din_vld = tbl[i].vld; din = tbl[i].din;
      cyc();
      chk($sformatf("v%0d_rdy", i),  32'(syncr_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_wen", i),  32'(wr_en),     32'(tbl[i].e_wen));
      chk($sformatf("v%0d_cnt", i),  32'(cap_cnt),   32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_done", i), 32'(cap_done),  32'(tbl[i].e_done));
      chk($sformatf("v%0d_err", i),  32'(cap_err),   32'(tbl[i].e_err));
      if (tbl[i].chk_ad) begin
        chk($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(tbl[i].e_addr));
        chk($sformatf("v%0d_data", i), 32'(wr_data), 32'(tbl[i].e_data));
      end
    end
    rst = 1'b0; sync_trig = 1'b0; mem_reset = 1'b0; din_vld = 1'b0;
    mon_en = 1'b1;

    // Full burst, then mem_reset clears status.
    run_full(16'h0010, "fb");
    mem_reset = 1'b1; cyc(); mem_reset = 1'b0;
    chk("mr_cnt", 32'(cap_cnt), 0);
    chk("mr_done", 32'(cap_done), 0);
    chk("mr_rdy", 32'(syncr_rdy), 1);

    // Gapped valid: 8 writes over 15 cycles.
    w0 = wr_seen;
    sync_trig = 1'b1; din_vld = 1'b0; cyc(); sync_trig = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back({3'(i), 16'h0040 + 16'(i)});
    for (int c = 0; c < 15; c++) begin
      din_vld = (c % 2 == 0);
      din = 16'h0040 + 16'(c / 2);
      cyc();
      if (c == 13) chk("gp_notdone", 32'(cap_done), 0);
    end
    chk("gp_done", 32'(cap_done), 1);
    chk("gp_cnt", 32'(cap_cnt), 8);
    din_vld = 1'b0; cyc();
    chk("gp_rdy", 32'(syncr_rdy), 1);
    chk("gp_q", 32'(q.size()), 0);
    chk("gp_nwr", 32'(wr_seen - w0), 8);

    // Watchdog abort after 3 samples.
    sync_trig = 1'b1; din_vld = 1'b0; cyc(); sync_trig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q.push_back({3'(i), 16'h0060 + 16'(i)});
      din_vld = 1'b1; din = 16'h0060 + 16'(i);
      cyc();
    end
    din_vld = 1'b0;
    idle = 0;
    while (!cap_err && idle < 40) begin
      cyc(); idle++;
    end
    chk("wd_idle", 32'(idle), 15);
    chk("wd_err", 32'(cap_err), 1);
    chk("wd_cnt", 32'(cap_cnt), 3);
    chk("wd_done", 32'(cap_done), 0);
    cyc();
    chk("wd_rdy", 32'(syncr_rdy), 1);
    chk("wd_sticky", 32'(cap_err), 1);
    chk("wd_q", 32'(q.size()), 0);

    // Trigger held for 20 cycles: single burst, ready only after release.
    w0 = wr_seen;
    for (int i = 0; i < 8; i++) q.push_back({3'(i), 16'h0080 + 16'(i)});
    sync_trig = 1'b1; din_vld = 1'b1; din = 16'h0080; cyc();
    for (int c = 0; c < 19; c++) begin
      din = 16'h0080 + 16'(c);
      cyc();
      chk($sformatf("ht_rdy%0d", c), 32'(syncr_rdy), 0);
    end
    sync_trig = 1'b0; cyc();
    chk("ht_rdy_back", 32'(syncr_rdy), 1);
    chk("ht_done", 32'(cap_done), 1);
    cyc(); cyc();
    chk("ht_nwr", 32'(wr_seen - w0), 8);
    chk("ht_cnt", 32'(cap_cnt), 8);
    chk("ht_q", 32'(q.size()), 0);
    din_vld = 1'b0;

    // Reset at the fifth sample, then a clean burst.
    sync_trig = 1'b1; din_vld = 1'b1; din = 16'h00A0; cyc(); sync_trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 16'h00A0 + 16'(i);
      q.push_back({3'(i), 16'h00A0 + 16'(i)});
      cyc();
    end
    rst = 1'b1; din = 16'h00A4; cyc(); rst = 1'b0; din_vld = 1'b0;
    chk("rm_wen", 32'(wr_en), 0);
    chk("rm_rdy", 32'(syncr_rdy), 1);
    chk("rm_cnt", 32'(cap_cnt), 0);
    chk("rm_addr", 32'(wr_addr), 0);
    chk("rm_data", 32'(wr_data), 0);
    cyc();
    chk("rm_q", 32'(q.size()), 0);
    run_full(16'h00B0, "rb");
    chk("rb_last_addr", 32'(wr_addr), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ta_sync_capture.md
# ta_sync_capture

Downstream partner of the capture sync controller. It accepts `sync_trig` and answers on `syncr_rdy`. It then writes one burst of `CAP_LEN` valid input samples into an external capture RAM through a registered write port. `mem_reset` from the controller clears its address and status between bursts. It sits between the sample front end and the capture memory, all in the `clk50` domain.

## Interface
Parameters:
- `DW`, 16, sample data width.
- `AW`, 10, capture RAM address width.
- `CAP_LEN`, 1024, samples per burst; legal range 2..2^AW.
- `TO_W`, 16, watchdog width; timeout fires after 2^TO_W−1 consecutive cycles without `din_vld` during capture.

Ports:
- `clk50` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `sync_trig` in 1: capture request from the controller; a level held until `syncr_rdy` is seen low.
- `syncr_rdy` out 1: high means idle and able to accept a trigger.
- `mem_reset` in 1: clears address, count and status; the controller pulses it only while `syncr_rdy`=1.
- `din` in DW: sample data.
- `din_vld` in 1: sample strobe.
- `wr_en` out 1: RAM write strobe.
- `wr_addr` out AW: RAM write address.
- `wr_data` out DW: RAM write data.
- `cap_cnt` out AW+1: number of samples written in the current or last burst.
- `cap_done` out 1: sticky; the last burst completed with `CAP_LEN` samples.
- `cap_err` out 1: sticky; the last burst was aborted by the watchdog.

## Operation
States:
- **S_RDY**: `syncr_rdy`=1.
  - `sync_trig`=1 → S_CAP. Clear `cap_cnt`, `cap_done`, `cap_err` and the watchdog. `syncr_rdy` goes to 0 on the next edge.
  - `mem_reset`=1 → clear `cap_cnt`, `cap_done`, `cap_err` and `wr_addr`; stay in S_RDY.
  - If `sync_trig` and `mem_reset` are both high, the trigger wins.
- **S_CAP**: `syncr_rdy`=0.
  - Each cycle with `din_vld`=1: `wr_en`=1, `wr_addr`=`cap_cnt[AW-1:0]`, `wr_data`=`din`; `cap_cnt` increments; the watchdog clears.
  - When the write of sample `CAP_LEN`−1 occurs: set `cap_done` → S_END.
  - Each cycle with `din_vld`=0: the watchdog increments. At all-ones, set `cap_err` → S_END; samples already written stay counted in `cap_cnt`.
  - `mem_reset` and `sync_trig` are ignored.
- **S_END**: `syncr_rdy`=0; `wr_en`=0.
  - Wait for `sync_trig`=0, then → S_RDY.
  - `syncr_rdy` therefore never rises while a trigger level is still present.
- `din_vld` outside S_CAP is dropped: no write and no count change.
- Address arithmetic:
  - `wr_addr` is `cap_cnt` truncated to AW bits.
  - With `CAP_LEN`=2^AW, the final address is 2^AW−1 and `cap_cnt` reaches 2^AW with no wrap.
  - `cap_cnt` never exceeds `CAP_LEN`.

## Timing
- Output values after `rst` (one edge):
  - State S_RDY.
  - `syncr_rdy`=1; the controller depends on this to issue its first `mem_reset`.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `cap_cnt`=0, `cap_done`=0, `cap_err`=0.
- `rst` mid-burst aborts immediately to the values above; nothing is written on the cycle `rst` is high.
- Trigger handshake: `sync_trig` sampled at edge N → `syncr_rdy`=0 after edge N.
- Sample latency: `din`/`din_vld` sampled at edge M → `wr_*` valid after edge M, for one cycle.
  - The first sample may be accepted on the same edge that leaves S_RDY? No: only samples from edge N+1 onward are captured.
- `cap_done`/`cap_err` assert on the edge of the final write or the timeout.
  - S_END → S_RDY is one edge after `sync_trig` is sampled low.
  - Minimum trigger-to-ready time is `CAP_LEN`+2 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `ta_sync_pkg` holds:
  - The state enum (S_RDY, S_CAP, S_END), shared with the controller's state constants.
  - The default `DW`/`AW`/`CAP_LEN`/`TO_W` constants.
- Sub-module `ta_sync_wdog`: a TO_W-bit inactivity counter with inputs `clr` and `tick` and output `expire`. It is reused by later sync stages.
- The rest is a single FSM plus address/count registers; estimate 150–250 lines of RTL.

## Test plan
- **Reset**: hold `rst` for 3 cycles → `syncr_rdy`=1 and all other outputs 0. Pulse `mem_reset` for 3 cycles → `cap_cnt`=0 and the state stays S_RDY.
- **Full burst**: `CAP_LEN`=8, `din_vld` always 1, `din`=0x10+i. Drive `sync_trig` as the controller does → 8 writes at addresses 0..7 with data 0x10..0x17, `cap_cnt`=8, `cap_done`=1. `syncr_rdy` returns 1 one cycle after `sync_trig` falls.
- **Gapped valid**: `din_vld` toggling 1/0 → 8 writes over 15 cycles, addresses contiguous, no write on the idle cycles.
- **Watchdog**: `TO_W`=4; 3 samples, then `din_vld`=0 → `cap_err`=1 exactly 15 idle cycles after the last write, `cap_cnt`=3, `cap_done`=0.
- **Held trigger**: `sync_trig` held high for 20 cycles with `CAP_LEN`=8 → `syncr_rdy` stays 0 until 1 cycle after `sync_trig` falls; there is no second burst.
- **Reset mid-burst and wrap boundary**: `rst` at sample 4 → outputs return to reset values, then a clean burst follows. Separately, `AW`=3, `CAP_LEN`=8 → last `wr_addr`=7 and `cap_cnt`=8.
